// File: rtl/mult8_pkg.sv
// Shared definitions for the sequential 8x8 shift-add multiplier.
package mult8_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int unsigned N_ITER   = 8;
    localparam logic [2:0]  LAST_CNT = 3'(N_ITER - 1);

endpackage

// File: rtl/csa8.sv
// 8-bit carry-select adder: ripple low nibble, both high-nibble sums precomputed.
module csa8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);

    logic [4:0] lo;
    logic [4:0] hi0;
    logic [4:0] hi1;
    logic [4:0] hi;

    always_comb begin
        lo   = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'b0000, cin};
        hi0  = {1'b0, a[7:4]} + {1'b0, b[7:4]};
        hi1  = {1'b0, a[7:4]} + {1'b0, b[7:4]} + 5'd1;
        hi   = lo[4] ? hi1 : hi0;
        sum  = {hi[3:0], lo[3:0]};
        cout = hi[4];
    end

endmodule

// File: rtl/mult8_seq.sv
// Sequential 8x8 unsigned shift-add multiplier; one csa8 addition per CALC cycle.
module mult8_seq
    import mult8_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        busy,
    output logic        done,
    output logic [15:0] product
);

    state_t      state_q, state_d;
    logic [7:0]  mcand_q, mcand_d;
    logic [15:0] p_q, p_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] product_q, product_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [7:0]  add_sum;
    logic        add_cout;

    csa8 u_csa8 (
        .a    (p_q[15:8]),
        .b    (mcand_q),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        p_d       = p_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    mcand_d = a;
                    p_d     = {8'h00, b};
                    cnt_d   = '0;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                // Adder carry-out lands in bit 15, so the shift never loses a bit.
                p_d   = p_q[0] ? {add_cout, add_sum, p_q[7:1]} : {1'b0, p_q[15:1]};
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == LAST_CNT) begin
                    product_d = p_d;
                    state_d   = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Outputs are registered alongside the state they decode.
        busy_d = (state_d == S_CALC);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            mcand_q   <= '0;
            p_q       <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            p_q       <= p_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: tb/tb_mult8_seq.sv
// Self-checking bench for mult8_seq: timeline reference model plus directed and random runs.
module tb_mult8_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  a = '0;
    logic [7:0]  b = '0;
    logic        busy;
    logic        done;
    logic [15:0] product;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    mult8_seq dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: phase 0 idle, 1..8 busy cycles, 9 the done cycle.
    int          phase = 0;
    logic [15:0] mdl_prod = '0;
    logic [15:0] mdl_pend = '0;
    logic        cmp_en = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            phase    <= 0;
            mdl_prod <= '0;
            cmp_en   <= 1'b1;
        end else if (phase == 0) begin
            if (start) begin
                phase    <= 1;
                mdl_pend <= 16'(a) * 16'(b);
            end
        end else if (phase == 8) begin
            phase    <= 9;
            mdl_prod <= mdl_pend;
        end else if (phase == 9) begin
            phase <= 0;
        end else begin
            phase <= phase + 1;
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("busy", 16'(busy), 16'(phase >= 1 && phase <= 8));
            chk("done", 16'(done), 16'(phase == 9));
            chk("product", product, mdl_prod);
        end
    end

    task automatic pulse_start(input logic [7:0] av, input logic [7:0] bv);
        @(negedge clk);
        a = av;
        b = bv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
    endtask

    task automatic wait_done(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) begin
            n_cmp++;
            n_err++;
            $display("FAIL done_timeout at cycle %0d: got no done expected done within 20 cycles", cyc);
        end
    endtask

    task automatic run_one(input string name, input logic [7:0] av, input logic [7:0] bv,
                           input logic [15:0] exp);
        bit seen;
        int busy_cnt;
        pulse_start(av, bv);
        busy_cnt = 0;
        while (busy && busy_cnt < 20) begin
            busy_cnt++;
            @(negedge clk);
        end
        chk({name, "_busy_len"}, 16'(busy_cnt), 16'd8);
        wait_done(seen);
        if (seen) chk(name, product, exp);
        @(negedge clk);
        chk({name, "_held"}, product, exp);
    endtask

    initial begin
        bit seen;
        int t_done [3];
        logic [7:0] ra, rb;

        repeat (2) @(negedge clk);
        chk("reset_busy", 16'(busy), 16'd0);
        chk("reset_done", 16'(done), 16'd0);
        chk("reset_product", product, 16'h0000);
        rst = 1'b0;

        run_one("p13x11", 8'd13, 8'd11, 16'h008F);
        chk("model_13x11", mdl_prod, 16'h008F);
        run_one("pFFxFF", 8'hFF, 8'hFF, 16'hFE01);
        chk("model_FFxFF", mdl_prod, 16'hFE01);
        run_one("p00xA5", 8'h00, 8'hA5, 16'h0000);
        run_one("p5Ax00", 8'h5A, 8'h00, 16'h0000);

        // Restart during CALC is ignored.
        pulse_start(8'd6, 8'd7);
        repeat (2) @(negedge clk);
        pulse_start(8'd200, 8'd100);
        wait_done(seen);
        if (seen) chk("ignore_restart", product, 16'd42);
        repeat (12) @(negedge clk);
        chk("no_second_done_prod", product, 16'd42);

        // Reset mid-CALC.
        pulse_start(8'd9, 8'd9);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", 16'(busy), 16'd0);
        chk("midrst_done", 16'(done), 16'd0);
        chk("midrst_product", product, 16'h0000);
        run_one("p3x8", 8'd3, 8'd8, 16'h0018);

        // Held start gives done pulses 10 cycles apart.
        @(negedge clk);
        a = 8'd2;
        b = 8'd7;
        start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            wait_done(seen);
            t_done[k] = cyc;
            if (seen) chk("held_start_prod", product, 16'h000E);
        end
        start = 1'b0;
        chk("held_spacing1", 16'(t_done[1] - t_done[0]), 16'd10);
        chk("held_spacing2", 16'(t_done[2] - t_done[1]), 16'd10);
        repeat (3) @(negedge clk);

        // Random transactions with occasional ignored restarts and mid-run resets.
        for (int n = 0; n < 40; n++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            pulse_start(ra, rb);
            case ($urandom_range(0, 5))
                0: begin
                    repeat ($urandom_range(0, 5)) @(negedge clk);
                    pulse_start(8'($urandom), 8'($urandom));
                    wait_done(seen);
                    if (seen) chk("rand_restart", product, 16'(ra) * 16'(rb));
                end
                1: begin
                    repeat ($urandom_range(0, 6)) @(negedge clk);
                    rst = 1'b1;
                    @(negedge clk);
                    rst = 1'b0;
                    chk("rand_rst_product", product, 16'h0000);
                end
                default: begin
                    wait_done(seen);
                    if (seen) chk("rand_product", product, 16'(ra) * 16'(rb));
                end
            endcase
            repeat ($urandom_range(1, 4)) @(negedge clk);
        end

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
